mem_arbiter: RTL and testbench

- Arbitrates the CPU instruction-fetch port and the CPU data port onto the single request interface of bram_fsm.
- Sits directly upstream of bram_fsm. It drives addr, data_in, read_en and write_en, and consumes data_out and done.
- Converts the bram_fsm level-held enable/done protocol into a per-port req/ack handshake.
- Uses two-way round-robin and a watchdog timeout.

---
 rtl/atk16_mem_pkg.sv | 18 +
 rtl/mem_arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atk16_mem_pkg.sv
// Shared types for the atk16 memory-side arbiter in front of bram_fsm.
package atk16_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DP = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin grant: on contention the port that did not win last time wins.
module mem_arb_rr2
    import atk16_mem_pkg::*;
(
    input  logic i_if_req,
    input  logic i_dp_req,
    input  gnt_t i_last_grant,
    output logic o_valid,
    output gnt_t o_grant
);

    always_comb begin
        o_valid = i_if_req | i_dp_req;
        o_grant = GNT_IF;
        if (i_if_req && i_dp_req) begin
            o_grant = (i_last_grant == GNT_DP) ? GNT_IF : GNT_DP;
        end else if (i_dp_req) begin
            o_grant = GNT_DP;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data port arbiter onto bram_fsm: turns the level enable/done protocol into
// per-port req/ack pulses, with round-robin and a watchdog on mem_done.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction; grants only while mem_done is low
// ST_ISSUE   | one enable held with stable addr/data, watchdog running
// ST_RELEASE | enables low, waiting for bram_fsm to drop mem_done
module mem_arbiter
    import atk16_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DATA_W-1:0] dp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              timeout_err
);

    localparam int             CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
    localparam bit             WD_EN    = (TIMEOUT != 0);

    arb_state_t        r_state,      w_state_nxt;
    gnt_t              r_last_grant, w_last_nxt;
    gnt_t              r_gnt,        w_gnt_nxt;
    logic [CNT_W-1:0]  r_wd_cnt,     w_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata,  w_wdata_nxt;
    logic              r_read_en,    w_read_en_nxt;
    logic              r_write_en,   w_write_en_nxt;
    logic              r_if_ack,     w_if_ack_nxt;
    logic              r_dp_ack,     w_dp_ack_nxt;
    logic [DATA_W-1:0] r_if_rdata,   w_if_rdata_nxt;
    logic [DATA_W-1:0] r_dp_rdata,   w_dp_rdata_nxt;
    logic              r_timeout_err, w_err_nxt;

    logic w_rr_valid;
    gnt_t w_rr_grant;

    mem_arb_rr2 u_rr2 (
        .i_if_req     (if_req),
        .i_dp_req     (dp_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_rr_valid),
        .o_grant      (w_rr_grant)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_last_nxt     = r_last_grant;
        w_gnt_nxt      = r_gnt;
        w_cnt_nxt      = r_wd_cnt;
        w_addr_nxt     = r_mem_addr;
        w_wdata_nxt    = r_mem_wdata;
        w_read_en_nxt  = r_read_en;
        w_write_en_nxt = r_write_en;
        w_if_ack_nxt   = 1'b0;
        w_dp_ack_nxt   = 1'b0;
        w_if_rdata_nxt = r_if_rdata;
        w_dp_rdata_nxt = r_dp_rdata;
        w_err_nxt      = r_timeout_err;

        case (r_state)
            ST_IDLE: begin
                // A high mem_done here is left over from before a reset or a slow release.
                if (!mem_done && w_rr_valid) begin
                    w_state_nxt = ST_ISSUE;
                    w_last_nxt  = w_rr_grant;
                    w_gnt_nxt   = w_rr_grant;
                    w_cnt_nxt   = CNT_LOAD;
                    if (w_rr_grant == GNT_IF) begin
                        w_addr_nxt    = if_addr;
                        w_read_en_nxt = 1'b1;
                    end else begin
                        w_addr_nxt     = dp_addr;
                        w_wdata_nxt    = dp_wdata;
                        w_read_en_nxt  = !dp_we;
                        w_write_en_nxt = dp_we;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_done || (WD_EN && r_wd_cnt == CNT_W'(1))) begin
                    w_state_nxt    = ST_RELEASE;
                    w_read_en_nxt  = 1'b0;
                    w_write_en_nxt = 1'b0;
                    if (r_gnt == GNT_IF) begin
                        w_if_ack_nxt = 1'b1;
                    end else begin
                        w_dp_ack_nxt = 1'b1;
                    end
                    if (mem_done) begin
                        if (r_gnt == GNT_IF) begin
                            w_if_rdata_nxt = mem_rdata;
                        end else if (r_read_en) begin
                            w_dp_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_wd_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!mem_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GNT_DP;
            r_gnt         <= GNT_IF;
            r_wd_cnt      <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_read_en     <= 1'b0;
            r_write_en    <= 1'b0;
            r_if_ack      <= 1'b0;
            r_dp_ack      <= 1'b0;
            r_if_rdata    <= '0;
            r_dp_rdata    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_nxt;
            r_gnt         <= w_gnt_nxt;
            r_wd_cnt      <= w_cnt_nxt;
            r_mem_addr    <= w_addr_nxt;
            r_mem_wdata   <= w_wdata_nxt;
            r_read_en     <= w_read_en_nxt;
            r_write_en    <= w_write_en_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_dp_ack      <= w_dp_ack_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_dp_rdata    <= w_dp_rdata_nxt;
            r_timeout_err <= w_err_nxt;
        end
    end

    assign if_ack       = r_if_ack;
    assign if_rdata     = r_if_rdata;
    assign dp_ack       = r_dp_ack;
    assign dp_rdata     = r_dp_rdata;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_read_en  = r_read_en;
    assign mem_write_en = r_write_en;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bram_fsm stand-in, transaction-level reference model checked
// every cycle, directed scenarios plus randomized traffic from both ports.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dp_req = 1'b0;
    logic          dp_we = 1'b0;
    logic [AW-1:0] dp_addr = '0;
    logic [DW-1:0] dp_wdata = '0;
    logic          dp_ack;
    logic [DW-1:0] dp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_ack(dp_ack), .dp_rdata(dp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // bram_fsm stand-in: done follows an enable after a latency, lingers for 'stale' cycles.
    logic [DW-1:0] smem [0:255];
    int stub_mode = 0;
    int stub_lat = 1;
    int stale_cfg = 0;
    bit stub_rnd = 1'b0;
    int en_cnt = 0, cur_lat = 0, stale_left = 0;
    bit started = 1'b0;

    initial forever begin
        @(posedge clk);
        #2;
        if (stub_mode == 1) begin
            mem_done = 1'b0; en_cnt = 0; stale_left = 0; started = 1'b0;
        end else if (stub_mode == 2) begin
            mem_done = 1'b1; en_cnt = 0; stale_left = 0; started = 1'b0;
        end else if (mem_read_en || mem_write_en) begin
            if (!mem_done) begin
                if (!started) begin
                    started = 1'b1;
                    if (stub_rnd) cur_lat = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
                    else cur_lat = stub_lat;
                end
                if (en_cnt >= cur_lat) begin
                    mem_done = 1'b1;
                    stale_left = stub_rnd ? $urandom_range(0, 2) : stale_cfg;
                    if (mem_write_en) smem[mem_addr[7:0]] = mem_wdata;
                    else mem_rdata = smem[mem_addr[7:0]];
                end else begin
                    en_cnt++;
                end
            end
        end else begin
            en_cnt = 0;
            started = 1'b0;
            if (mem_done) begin
                if (stale_left > 0) stale_left--;
                else mem_done = 1'b0;
            end
        end
    end

    // Reference model: one transaction in flight, one rule per phase of the handshake.
    logic [DW-1:0] mmem [0:255];
    bit m_busy = 0, m_rel = 0, m_last = 1, m_port = 0, m_write = 0;
    int m_cyc = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_if_rd = '0, e_dp_rd = '0;
    bit e_ren = 0, e_wen = 0, e_ia = 0, e_da = 0, e_err = 0;

    task automatic model_reset();
        m_busy = 0; m_rel = 0; m_last = 1; m_cyc = 0;
        e_ren = 0; e_wen = 0; e_ia = 0; e_da = 0; e_err = 0;
        e_if_rd = '0; e_dp_rd = '0;
    endtask

    task automatic model_finish();
        if (m_port == 0) e_ia = 1; else e_da = 1;
        e_ren = 0; e_wen = 0; m_busy = 0; m_rel = 1;
    endtask

    task automatic model_step();
        e_ia = 0; e_da = 0;
        if (m_busy) begin
            if (mem_done) begin
                if (m_port == 0) e_if_rd = mmem[e_addr[7:0]];
                else if (m_write) mmem[e_addr[7:0]] = e_wdata;
                else e_dp_rd = mmem[e_addr[7:0]];
                model_finish();
            end else begin
                m_cyc++;
                if (m_cyc == TO) begin
                    e_err = 1;
                    model_finish();
                end
            end
        end else if (m_rel) begin
            if (!mem_done) m_rel = 0;
        end else if (!mem_done && (if_req || dp_req)) begin
            m_port = (if_req && dp_req) ? !m_last : dp_req;
            m_last = m_port;
            m_busy = 1;
            m_cyc = 0;
            m_write = m_port && dp_we;
            e_addr = m_port ? dp_addr : if_addr;
            if (m_port) e_wdata = dp_wdata;
            e_ren = !m_write;
            e_wen = m_write;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else model_step();
    end

    int cnt_ia = 0, cnt_da = 0, cnt_wen = 0;

    initial forever begin
        @(negedge clk);
        if (if_ack) cnt_ia++;
        if (dp_ack) cnt_da++;
        if (mem_write_en) cnt_wen++;
        chk("mem_read_en", 32'(mem_read_en), 32'(e_ren));
        chk("mem_write_en", 32'(mem_write_en), 32'(e_wen));
        chk("if_ack", 32'(if_ack), 32'(e_ia));
        chk("dp_ack", 32'(dp_ack), 32'(e_da));
        chk("if_rdata", 32'(if_rdata), 32'(e_if_rd));
        chk("dp_rdata", 32'(dp_rdata), 32'(e_dp_rd));
        chk("timeout_err", 32'(timeout_err), 32'(e_err));
        if (e_ren || e_wen) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_wen) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return if_ack;
            1: return dp_ack;
            default: return mem_read_en;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        int n = 0;
        while (!sig(which) && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(sig(which)), 1);
    endtask

    task automatic drive_if(input int n);
        if_addr = 16'($urandom_range(16'h40, 16'h7f));
        if_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_sig(0, "rnd_if_ack_wait");
            if (i == n - 1 || $urandom_range(0, 1) == 1) begin
                if_req = 1'b0;
                step();
                repeat ($urandom_range(0, 2)) step();
                if (i < n - 1) begin
                    if_addr = 16'($urandom_range(16'h40, 16'h7f));
                    if_req = 1'b1;
                end
            end else begin
                if_addr = 16'($urandom_range(16'h40, 16'h7f));
                step();
            end
        end
    endtask

    task automatic drive_dp(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            dp_we = 1'($urandom_range(0, 1));
            dp_addr = 16'($urandom_range(16'h40, 16'h7f));
            dp_wdata = 16'($urandom);
            dp_req = 1'b1;
            wait_sig(1, "rnd_dp_ack_wait");
            dp_req = 1'b0;
            step();
        end
    endtask

    int order[$];
    int n, n_en, t_ack, t_en;

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = 16'(i) ^ 16'h5A5A;
            mmem[i] = 16'(i) ^ 16'h5A5A;
        end
        smem[16] = 16'hBEEF;
        mmem[16] = 16'hBEEF;
        #1 rst = 1'b0;

        // Both ports requesting straight out of reset.
        if_req = 1'b1; if_addr = 16'h0020;
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 16'h0030;
        repeat (3) step();
        chk("reset_read_en", 32'(mem_read_en), 0);
        chk("reset_write_en", 32'(mem_write_en), 0);
        chk("reset_if_ack", 32'(if_ack), 0);
        chk("reset_timeout_err", 32'(timeout_err), 0);
        chk("reset_if_rdata", 32'(if_rdata), 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (order.size() < 4 && n < 200) begin
            step();
            if (if_ack) order.push_back(0);
            if (dp_ack) order.push_back(1);
            n++;
        end
        if_req = 1'b0; dp_req = 1'b0;
        chk("contention_ack_count", 32'(order.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("contention_order", (i < order.size()) ? 32'(order[i]) : 32'd9, 32'(i % 2));

        // Single fetch.
        repeat (3) step();
        n = cnt_ia; n_en = cnt_da; t_en = cnt_wen;
        if_addr = 16'h0010; if_req = 1'b1;
        wait_sig(0, "fetch_ack_wait");
        if_req = 1'b0;
        chk("fetch_rdata", 32'(if_rdata), 32'h0000BEEF);
        repeat (3) step();
        chk("fetch_ack_pulses", 32'(cnt_ia - n), 1);
        chk("fetch_no_dp_ack", 32'(cnt_da - n_en), 0);
        chk("fetch_no_write", 32'(cnt_wen - t_en), 0);

        // Write then read back on the data port, req kept high between them.
        dp_we = 1'b1; dp_addr = 16'h0001; dp_wdata = 16'h1234; dp_req = 1'b1;
        wait_sig(1, "write_ack_wait");
        chk("enables_low_after_write", 32'({mem_read_en, mem_write_en}), 0);
        dp_we = 1'b0;
        step();
        wait_sig(1, "read_ack_wait");
        dp_req = 1'b0;
        chk("write_landed", 32'(smem[1]), 32'h00001234);
        chk("readback_rdata", 32'(dp_rdata), 32'h00001234);

        // mem_done on the last watchdog cycle completes normally.
        repeat (2) step();
        stub_lat = 7;
        if_addr = 16'h0022; if_req = 1'b1;
        wait_sig(0, "done_wins_ack_wait");
        if_req = 1'b0;
        chk("done_wins_rdata", 32'(if_rdata), 32'h00005A78);
        chk("done_wins_no_err", 32'(timeout_err), 0);
        stub_lat = 1;

        // Randomized traffic on both ports.
        repeat (2) step();
        stub_rnd = 1'b1;
        fork
            drive_if(25);
            drive_dp(25);
        join
        repeat (6) step();
        stub_rnd = 1'b0;
        chk("err_before_timeout", 32'(timeout_err), 0);

        // Watchdog abort with mem_done stuck low.
        stub_mode = 1;
        if_addr = 16'h0005; if_req = 1'b1;
        wait_sig(2, "timeout_enable_wait");
        n_en = 0; n = 0;
        while (!if_ack && n < 100) begin
            if (mem_read_en) n_en++;
            step();
            n++;
        end
        chk("timeout_ack_seen", 32'(if_ack), 1);
        chk("timeout_enable_cycles", 32'(n_en), 8);
        chk("timeout_err_set", 32'(timeout_err), 1);
        if_req = 1'b0;
        stub_mode = 0;
        repeat (3) step();
        if_addr = 16'h0023; if_req = 1'b1;
        wait_sig(0, "post_timeout_ack_wait");
        if_req = 1'b0;
        chk("timeout_err_sticky", 32'(timeout_err), 1);

        // Reset mid-transaction, then a stale mem_done from the unreset memory.
        repeat (2) step();
        stub_lat = 5;
        if_addr = 16'h0011; if_req = 1'b1;
        wait_sig(2, "reset_test_enable_wait");
        #2 rst = 1'b0;
        #1;
        chk("async_reset_read_en", 32'(mem_read_en), 0);
        chk("async_reset_if_ack", 32'(if_ack), 0);
        chk("async_reset_if_rdata", 32'(if_rdata), 0);
        chk("async_reset_err", 32'(timeout_err), 0);
        stub_mode = 2;
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stuck_done_no_enable", 32'(mem_read_en), 0);
        end
        stub_mode = 0;
        stub_lat = 1;
        wait_sig(0, "after_reset_ack_wait");
        if_req = 1'b0;
        chk("after_reset_rdata", 32'(if_rdata), 32'h00005A4B);

        // mem_done lingers five cycles into RELEASE with a data read pending.
        repeat (2) step();
        stale_cfg = 5;
        if_addr = 16'h0012; if_req = 1'b1;
        wait_sig(0, "stale_fetch_ack_wait");
        t_ack = cyc;
        if_req = 1'b0;
        dp_we = 1'b0; dp_addr = 16'h0031; dp_req = 1'b1;
        wait_sig(2, "stale_dp_enable_wait");
        t_en = cyc;
        chk("stale_grant_gap", 32'(t_en - t_ack), 7);
        wait_sig(1, "stale_dp_ack_wait");
        dp_req = 1'b0;
        chk("stale_dp_rdata", 32'(dp_rdata), 32'h00005A6B);
        stale_cfg = 0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
